dm_lsu: RTL and testbench

- Parametrised successor to the single-cycle data memory.
- Word-organised RAM behind a request/done handshake with configurable access latency.
- Supports byte, halfword and word stores/loads with sign/zero extension, base-address windowing and exception reporting (misaligned, out-of-range, illegal op).
- Sits in the MEM stage; the pipeline stalls on busy and consumes rdata/exc on done.

---
 rtl/dm_lsu.sv | 196 +++++++++++++++++++
 tb/tb_dm_lsu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// dm_lsu: word-organised data memory behind a req/done handshake.
// Byte/half/word access with extension, windowing and exception codes.
module dm_lsu #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  exc
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) * 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           we_q, we_d;
    logic [2:0]     op_q, op_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    rdata_q, rdata_d;
    logic [1:0]     exc_q, exc_d;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic [31:0]    off_in, off_q;
    logic [AW-1:0]  widx;
    logic [31:0]    rd_word, wr_word, ld_val;
    logic [1:0]     err;
    logic           mem_we;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;

    assign off_in  = addr - BASE_ADDR;
    assign off_q   = addr_q - BASE_ADDR;
    assign widx    = AW'(off_q >> 2);
    assign rd_word = mem_q[widx];

    // Checked on the request inputs so the error path can skip WAIT.
    always_comb begin
        err = 2'd0;
        if (op > 3'd4)
            err = 2'd3;
        else if (off_in >= MEM_BYTES)
            err = 2'd2;
        else if (((op == 3'd1) || (op == 3'd2)) && addr[0])
            err = 2'd1;
        else if ((op == 3'd0) && (addr[1:0] != 2'b00))
            err = 2'd1;
    end

    always_comb begin
        ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
        ld_byte = rd_word[7:0];
        case (addr_q[1:0])
            2'd1:    ld_byte = rd_word[15:8];
            2'd2:    ld_byte = rd_word[23:16];
            2'd3:    ld_byte = rd_word[31:24];
            default: ld_byte = rd_word[7:0];
        endcase
        case (op_q)
            3'd1:    ld_val = {{16{ld_half[15]}}, ld_half};
            3'd2:    ld_val = {16'h0000, ld_half};
            3'd3:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'd4:    ld_val = {24'h000000, ld_byte};
            default: ld_val = rd_word;
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        case (op_q)
            3'd0: wr_word = wdata_q;
            3'd1, 3'd2: begin
                if (addr_q[1])
                    wr_word[31:16] = wdata_q[15:0];
                else
                    wr_word[15:0] = wdata_q[15:0];
            end
            3'd3, 3'd4: begin
                case (addr_q[1:0])
                    2'd0:    wr_word[7:0]   = wdata_q[7:0];
                    2'd1:    wr_word[15:8]  = wdata_q[7:0];
                    2'd2:    wr_word[23:16] = wdata_q[7:0];
                    default: wr_word[31:24] = wdata_q[7:0];
                endcase
            end
            default: wr_word = rd_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        mem_we  = 1'b0;
        if (state_q == S_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                state_d = S_DONE;
                mem_we  = we_q;
                rdata_d = we_q ? 32'h0 : ld_val;
                exc_d   = 2'd0;
            end
        end else if (req) begin
            we_d    = we;
            op_d    = op;
            addr_d  = addr;
            wdata_d = wdata;
            pc_d    = pc;
            rdata_d = 32'h0;
            exc_d   = err;
            if (err != 2'd0) begin
                state_d = S_DONE;
            end else begin
                state_d = S_WAIT;
                cnt_d   = CW'(LATENCY - 1);
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
            rdata_d = 32'h0;
            exc_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            exc_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++)
                mem_q[i] <= 32'h0;
        end else if (mem_we) begin
            mem_q[widx] <= wr_word;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && mem_we)
            $display("%d@%h: *%h <= %h", $time, pc_q,
                     {addr_q[31:2], 2'b00}, wr_word);
    end
`endif

    assign busy  = (state_q == S_WAIT);
    assign done  = (state_q == S_DONE);
    assign rdata = rdata_q;
    assign exc   = exc_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: one LATENCY=1 and one LATENCY=3 instance
// sharing clock, reset and request fields.
module tb_dm_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req1, req3;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr, wdata, pc;
    logic        busy1, done1, busy3, done3;
    logic [31:0] rdata1, rdata3;
    logic [1:0]  exc1, exc3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_lsu #(.LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we), .op(op),
        .addr(addr), .wdata(wdata), .pc(pc),
        .busy(busy1), .done(done1), .rdata(rdata1), .exc(exc1)
    );

    dm_lsu #(.LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we), .op(op),
        .addr(addr), .wdata(wdata), .pc(pc),
        .busy(busy3), .done(done3), .rdata(rdata3), .exc(exc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge where done is seen.
    // edges counts posedges from request presentation to done.
    task automatic access(input bit sel, input logic w,
                          input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic [1:0] ex, output int edges,
                          output int busy_n);
        we = w; op = o; addr = a; wdata = d; pc = pc + 32'd4;
        if (sel) req3 = 1'b1; else req1 = 1'b1;
        edges = 0;
        busy_n = 0;
        @(posedge clk);
        edges++;
        @(negedge clk);
        req1 = 1'b0;
        req3 = 1'b0;
        while (!(sel ? done3 : done1) && edges < 40) begin
            if (sel ? busy3 : busy1) busy_n++;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        rd = sel ? rdata3 : rdata1;
        ex = sel ? exc3 : exc1;
    endtask

    task automatic run(input string tag, input bit sel, input logic w,
                       input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd,
                       input logic [1:0] eex, input int eedges);
        logic [31:0] rd;
        logic [1:0]  ex;
        int          edges, bn;
        access(sel, w, o, a, d, rd, ex, edges, bn);
        chk({tag, ".rdata"}, rd, erd);
        chk({tag, ".exc"}, 32'(ex), 32'(eex));
        chk({tag, ".edges"}, edges, eedges);
    endtask

    task automatic chk_idle1(input string tag);
        @(negedge clk);
        chk({tag, ".done_low"}, 32'(done1), 32'd0);
        chk({tag, ".rdata_clr"}, rdata1, 32'h0);
        chk({tag, ".exc_clr"}, 32'(exc1), 32'd0);
    endtask

    logic [31:0] rd;
    logic [1:0]  ex;
    int          edges, bn;

    initial begin
        reset = 1'b1;
        req1 = 1'b0; req3 = 1'b0; we = 1'b0; op = 3'd0;
        addr = 32'h0; wdata = 32'h0; pc = 32'h0000_1000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy1), 32'd0);
        chk("rst.done", 32'(done1), 32'd0);
        chk("rst.rdata", rdata1, 32'h0);
        chk("rst.exc", 32'(exc1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("lw10", 0, 1'b0, 3'd0, 32'h10, 32'h0, 32'h0, 2'd0, 2);
        chk_idle1("lw10");

        run("sw20", 0, 1'b1, 3'd0, 32'h20, 32'h1122_3344, 32'h0, 2'd0, 2);
        run("sb21", 0, 1'b1, 3'd3, 32'h21, 32'h0000_00AA, 32'h0, 2'd0, 2);
        run("lw20", 0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h1122_AA44, 2'd0, 2);

        run("sh22", 0, 1'b1, 3'd1, 32'h22, 32'h0000_8001, 32'h0, 2'd0, 2);
        run("lh22", 0, 1'b0, 3'd1, 32'h22, 32'h0, 32'hFFFF_8001, 2'd0, 2);
        run("lhu22", 0, 1'b0, 3'd2, 32'h22, 32'h0, 32'h0000_8001, 2'd0, 2);
        run("lb23", 0, 1'b0, 3'd3, 32'h23, 32'h0, 32'hFFFF_FF80, 2'd0, 2);
        run("lbu22", 0, 1'b0, 3'd4, 32'h22, 32'h0, 32'h0000_0001, 2'd0, 2);
        run("lbu21", 0, 1'b0, 3'd4, 32'h21, 32'h0, 32'h0000_00AA, 2'd0, 2);
        run("lw20b", 0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h8001_AA44, 2'd0, 2);

        run("lw2", 0, 1'b0, 3'd0, 32'h2, 32'h0, 32'h0, 2'd1, 1);
        run("sh1", 0, 1'b1, 3'd1, 32'h1, 32'hFFFF, 32'h0, 2'd1, 1);
        run("lwoor", 0, 1'b0, 3'd0, 32'h3000, 32'h0, 32'h0, 2'd2, 1);
        run("op6", 0, 1'b0, 3'd6, 32'h20, 32'h0, 32'h0, 2'd3, 1);
        run("op7oor", 0, 1'b1, 3'd7, 32'h3001, 32'h0, 32'h0, 2'd3, 1);
        run("oormis", 0, 1'b0, 3'd0, 32'h3002, 32'h0, 32'h0, 2'd2, 1);
        run("swwrap", 0, 1'b1, 3'd0, 32'hFFFF_FFFC, 32'h5, 32'h0, 2'd2, 1);
        chk_idle1("err");
        run("lw0", 0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2);
        run("lw20c", 0, 1'b0, 3'd0, 32'h20, 32'h0, 32'h8001_AA44, 2'd0, 2);
        run("lwlast", 0, 1'b0, 3'd0, 32'h2FFC, 32'h0, 32'h0, 2'd0, 2);

        access(1, 1'b1, 3'd0, 32'h40, 32'hCAFE_BABE, rd, ex, edges, bn);
        chk("l3.sw.edges", edges, 4);
        chk("l3.sw.busy", bn, 3);
        access(1, 1'b0, 3'd0, 32'h40, 32'h0, rd, ex, edges, bn);
        chk("l3.b2b.edges", edges, 4);
        chk("l3.b2b.busy", bn, 3);
        chk("l3.b2b.rdata", rd, 32'hCAFE_BABE);
        @(negedge clk);

        req3 = 1'b1; we = 1'b1; op = 3'd0;
        addr = 32'h44; wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        chk("l3.ign.busy1", 32'(busy3), 32'd1);
        addr = 32'h48; wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk("l3.ign.busy2", 32'(busy3), 32'd1);
        req3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("l3.ign.busy3", 32'(busy3), 32'd1);
        req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        chk("l3.ign.done", 32'(done3), 32'd1);
        chk("l3.ign.exc", 32'(exc3), 32'd0);
        @(negedge clk);
        chk("l3.ign.idle", 32'(done3 | busy3), 32'd0);
        run("l3.lw48", 1, 1'b0, 3'd0, 32'h48, 32'h0, 32'h0, 2'd0, 4);
        run("l3.lw44", 1, 1'b0, 3'd0, 32'h44, 32'h0, 32'h1234_5678, 2'd0, 4);

        req3 = 1'b1; we = 1'b1; op = 3'd0;
        addr = 32'h4C; wdata = 32'h7777_7777;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        chk("rstw.busy", 32'(busy3), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rstw.busy0", 32'(busy3), 32'd0);
        chk("rstw.done0", 32'(done3), 32'd0);
        @(negedge clk);
        chk("rstw.nodone", 32'(done3), 32'd0);
        run("rstw.lw4c", 1, 1'b0, 3'd0, 32'h4C, 32'h0, 32'h0, 2'd0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
